// File: rtl/pll_reconfig_writer.sv
// Purpose: Avalon-MM master that writes a new N/M/C0/C1 (and optional K) counter set into a fractional PLL reconfig port, starts it, and supervises relock.
// Latency: with a zero-wait slave and lock already present, done pulses 8+SETTLE_CYC cycles after cfg_req (9+SETTLE_CYC with the K write).
// Backpressure: mgmt_waitrequest stalls the current write with address/data/write held stable; cfg_req is only accepted while idle.
//
// Ports:
//   mgmt_clk, mgmt_reset_n     - management clock, synchronous active-low reset
//   cfg_req, cfg_n/m/c0/c1/k   - request strobe and counter set (18-bit words: [7:0] low, [15:8] high, [16] bypass, [17] odd)
//   busy, done, error          - status: busy level, one-cycle done / error pulses
//   mgmt_address/write/writedata, mgmt_waitrequest - Avalon-MM write master
//   pll_locked                 - PLL lock, asynchronous, synchronised internally
// Optional feature macro: PLLCFG_FRAC_EN adds the fractional K write (addr 0x07) between M and C0.
module pll_reconfig_writer #(
  parameter int SETTLE_CYC   = 64,
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int TO_W         = 21
) (
  input  logic        mgmt_clk,
  input  logic        mgmt_reset_n,
  input  logic        cfg_req,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c0,
  input  logic [17:0] cfg_c1,
  input  logic [31:0] cfg_k,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

`ifdef PLLCFG_FRAC_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_SETTLE,
    S_LOCKWAIT,
    S_DONE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [17:0] n;
    logic [17:0] m;
    logic [17:0] c0;
    logic [17:0] c1;
  } cfg_t;

  state_t          state, state_nxt;
  cfg_t            cfg_q;
  logic [2:0]      wr_idx;
  logic [ST_W-1:0] settle_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      lock_sync;
  logic            locked_s;
  logic [5:0]      wr_addr;
  logic [31:0]     wr_data;

`ifdef PLLCFG_FRAC_EN
  logic [31:0]     k_q;
`else
  // K is not used in this build; the port stays for interface stability.
  logic            unused_k;
  assign unused_k = ^cfg_k;
`endif

  assign locked_s = lock_sync[1];

  // Register sequence; the index advances only when a write is accepted.
  always_comb begin
    wr_addr = 6'h00;
    wr_data = 32'h0;
    case (wr_idx)
      3'd0: begin wr_addr = 6'h00; wr_data = 32'h0;                 end // waitrequest mode
      3'd1: begin wr_addr = 6'h03; wr_data = {14'b0, cfg_q.n};      end
      3'd2: begin wr_addr = 6'h04; wr_data = {14'b0, cfg_q.m};      end
`ifdef PLLCFG_FRAC_EN
      3'd3: begin wr_addr = 6'h07; wr_data = k_q;                   end
      3'd4: begin wr_addr = 6'h05; wr_data = {9'b0, 5'd0, cfg_q.c0}; end
      3'd5: begin wr_addr = 6'h05; wr_data = {9'b0, 5'd1, cfg_q.c1}; end
      3'd6: begin wr_addr = 6'h02; wr_data = 32'h1;                 end // start
`else
      3'd3: begin wr_addr = 6'h05; wr_data = {9'b0, 5'd0, cfg_q.c0}; end
      3'd4: begin wr_addr = 6'h05; wr_data = {9'b0, 5'd1, cfg_q.c1}; end
      3'd5: begin wr_addr = 6'h02; wr_data = 32'h1;                 end // start
`endif
      default: begin wr_addr = 6'h00; wr_data = 32'h0; end
    endcase
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_nxt      = state;
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    mgmt_write     = 1'b0;
    mgmt_address   = 6'h00;
    mgmt_writedata = 32'h0;
    case (state)
      S_IDLE: begin
        if (cfg_req) state_nxt = S_WR;
      end
      S_WR: begin
        busy           = 1'b1;
        mgmt_write     = 1'b1;
        mgmt_address   = wr_addr;
        mgmt_writedata = wr_data;
        if (!mgmt_waitrequest && wr_idx == LAST_IDX) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == ST_W'(SETTLE_CYC - 1)) state_nxt = S_LOCKWAIT;
      end
      S_LOCKWAIT: begin
        busy = 1'b1;
        // Lock takes priority over a coincident timeout.
        if (locked_s)                                 state_nxt = S_DONE;
        else if (to_cnt == TO_W'(LOCK_TIMEOUT - 1))   state_nxt = S_ERR;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        error     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge mgmt_clk) begin
    if (!mgmt_reset_n) begin
      state      <= S_IDLE;
      cfg_q      <= '0;
      wr_idx     <= '0;
      settle_cnt <= '0;
      to_cnt     <= '0;
      lock_sync  <= '0;
`ifdef PLLCFG_FRAC_EN
      k_q        <= '0;
`endif
    end else begin
      state     <= state_nxt;
      lock_sync <= {lock_sync[0], pll_locked};
      case (state)
        S_IDLE: begin
          if (cfg_req) begin
            cfg_q.n  <= cfg_n;
            cfg_q.m  <= cfg_m;
            cfg_q.c0 <= cfg_c0;
            cfg_q.c1 <= cfg_c1;
`ifdef PLLCFG_FRAC_EN
            k_q      <= cfg_k;
`endif
            wr_idx   <= '0;
          end
        end
        S_WR: begin
          settle_cnt <= '0;
          if (!mgmt_waitrequest) wr_idx <= wr_idx + 3'd1;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          to_cnt     <= '0;
        end
        S_LOCKWAIT: begin
          to_cnt <= to_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_writer.sv
// Purpose: directed self-checking bench for pll_reconfig_writer.
// Latency: checks done/error cycle positions against hand-derived counts.
// Backpressure: stalls the M write with waitrequest and checks stability.
module tb_pll_reconfig_writer;

  localparam int S  = 16;
  localparam int LT = 200;

`ifdef PLLCFG_FRAC_EN
  localparam int NW = 7;
`else
  localparam int NW = 6;
`endif

  logic        mgmt_clk = 1'b0;
  logic        mgmt_reset_n;
  logic        cfg_req;
  logic [17:0] cfg_n, cfg_m, cfg_c0, cfg_c1;
  logic [31:0] cfg_k;
  logic        busy, done, error;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;
  logic        pll_locked;

  always #5 mgmt_clk = ~mgmt_clk;

  pll_reconfig_writer #(
    .SETTLE_CYC  (S),
    .LOCK_TIMEOUT(LT),
    .TO_W        (8)
  ) dut (
    .mgmt_clk        (mgmt_clk),
    .mgmt_reset_n    (mgmt_reset_n),
    .cfg_req         (cfg_req),
    .cfg_n           (cfg_n),
    .cfg_m           (cfg_m),
    .cfg_c0          (cfg_c0),
    .cfg_c1          (cfg_c1),
    .cfg_k           (cfg_k),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .mgmt_address    (mgmt_address),
    .mgmt_write      (mgmt_write),
    .mgmt_writedata  (mgmt_writedata),
    .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked      (pll_locked)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge mgmt_clk);
    #1;
  endtask

  // Results of the last run_req call.
  logic [5:0]  wa[$];
  logic [31:0] wd[$];
  int done_cyc, err_cyc, n_done, n_err, stab_bad, extra_busy, busy_start;

  // Issue one request and observe it. The write at stall_addr is held off
  // for stall_n cycles. Inputs are scrambled and cfg_req re-pulsed while
  // busy, and cfg_req is pulsed again in the done/error cycle.
  task automatic run_req(input logic [17:0] n, input logic [17:0] m,
                         input logic [17:0] c0, input logic [17:0] c1,
                         input logic [31:0] k, input logic [5:0] stall_addr,
                         input int stall_n, input int budget);
    int cyc, left, end_cyc;
    logic hold_vld, stalled;
    logic [5:0]  hold_a;
    logic [31:0] hold_d;
    wa.delete(); wd.delete();
    done_cyc = -1; err_cyc = -1; n_done = 0; n_err = 0;
    stab_bad = 0; extra_busy = 0; busy_start = 0;
    cyc = 0; left = stall_n; end_cyc = -1; hold_vld = 1'b0; stalled = 1'b0;
    hold_a = '0; hold_d = '0;
    cfg_n = n; cfg_m = m; cfg_c0 = c0; cfg_c1 = c1; cfg_k = k;
    cfg_req = 1'b1;
    while (cyc < budget) begin
      tick();
      cyc++;
      cfg_req = 1'b0;
      mgmt_waitrequest = 1'b0;
      if (cyc == 1) busy_start = busy;
      if (cyc == 2) begin
        cfg_n = ~n; cfg_m = ~m; cfg_c0 = ~c0; cfg_c1 = ~c1; cfg_k = ~k;
      end
      if (cyc == 3) cfg_req = 1'b1;
      if (end_cyc >= 0) begin
        if (busy || mgmt_write) extra_busy++;
        if (done) n_done++;
        if (error) n_err++;
        if (cyc >= end_cyc + 5) break;
        continue;
      end
      if (done) begin
        n_done++; done_cyc = cyc; end_cyc = cyc;
        if (busy) extra_busy++;
        cfg_req = 1'b1;
      end
      if (error) begin
        n_err++; err_cyc = cyc; end_cyc = cyc;
        if (busy) extra_busy++;
        cfg_req = 1'b1;
      end
      if (mgmt_write) begin
        if (!stalled && mgmt_address == stall_addr && left > 0) begin
          if (!hold_vld) begin
            hold_vld = 1'b1; hold_a = mgmt_address; hold_d = mgmt_writedata;
          end else if (mgmt_address != hold_a || mgmt_writedata != hold_d) begin
            stab_bad++;
          end
          mgmt_waitrequest = 1'b1;
          left--;
        end else begin
          if (hold_vld) begin
            if (mgmt_address != hold_a || mgmt_writedata != hold_d) stab_bad++;
            hold_vld = 1'b0;
            stalled  = 1'b1;
          end
          wa.push_back(mgmt_address);
          wd.push_back(mgmt_writedata);
        end
      end
    end
    cfg_req = 1'b0;
    mgmt_waitrequest = 1'b0;
  endtask

  task automatic check_seq(input string tag, input logic [17:0] n, input logic [17:0] m,
                           input logic [17:0] c0, input logic [17:0] c1, input logic [31:0] k);
    logic [5:0]  ea[$];
    logic [31:0] ed[$];
    ea = '{6'h00, 6'h03, 6'h04};
    ed = '{32'h0, {14'b0, n}, {14'b0, m}};
`ifdef PLLCFG_FRAC_EN
    ea.push_back(6'h07); ed.push_back(k);
`endif
    ea.push_back(6'h05); ed.push_back({14'b0, c0});
    ea.push_back(6'h05); ed.push_back(32'h0004_0000 | {14'b0, c1});
    ea.push_back(6'h02); ed.push_back(32'h1);
    check_val({tag, "_nwrites"}, 64'(wa.size()), 64'(NW));
    for (int i = 0; i < NW && i < wa.size(); i++) begin
      check_val($sformatf("%s_addr%0d", tag, i), 64'(wa[i]), 64'(ea[i]));
      check_val($sformatf("%s_data%0d", tag, i), 64'(wd[i]), 64'(ed[i]));
    end
  endtask

  initial begin
    int bad, cyc;
    mgmt_reset_n = 1'b0; cfg_req = 1'b0; mgmt_waitrequest = 1'b0;
    cfg_n = '0; cfg_m = '0; cfg_c0 = '0; cfg_c1 = '0; cfg_k = '0;
    pll_locked = 1'b1;
    repeat (3) tick();
    check_val("rst_busy", busy, 0);
    check_val("rst_write", mgmt_write, 0);
    check_val("rst_addr", mgmt_address, 0);
    check_val("rst_data", mgmt_writedata, 0);
    check_val("rst_done_err", {done, error}, 0);
    mgmt_reset_n = 1'b1;

    // Idle for 100 cycles without a request.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy || mgmt_write || done || error || mgmt_address != 0 || mgmt_writedata != 0) bad++;
    end
    check_val("idle_quiet", bad, 0);

    // Basic request, zero-wait slave, already locked.
    run_req(18'h00101, 18'h01616, 18'h20303, 18'h00404, 32'h8000_0000, 6'h3f, 0, 400);
    check_val("basic_busy_start", busy_start, 1);
    check_seq("basic", 18'h00101, 18'h01616, 18'h20303, 18'h00404, 32'h8000_0000);
    check_val("basic_done_cyc", done_cyc, NW + 2 + S);
    check_val("basic_n_done", n_done, 1);
    check_val("basic_n_err", n_err, 0);
    check_val("basic_busy_after", extra_busy, 0);

    // M write stalled for 5 cycles.
    run_req(18'h3a5c3, 18'h0f00f, 18'h10001, 18'h2ffff, 32'h1234_5678, 6'h04, 5, 400);
    check_seq("stall", 18'h3a5c3, 18'h0f00f, 18'h10001, 18'h2ffff, 32'h1234_5678);
    check_val("stall_stable", stab_bad, 0);
    check_val("stall_done_cyc", done_cyc, NW + 2 + S + 5);
    check_val("stall_n_done", n_done, 1);

    // Lock never comes: timeout.
    pll_locked = 1'b0;
    repeat (3) tick();
    run_req(18'h00202, 18'h00303, 18'h00404, 18'h00505, 32'h0, 6'h3f, 0, 600);
    check_val("to_err_cyc", err_cyc, NW + 1 + S + LT);
    check_val("to_n_err", n_err, 1);
    check_val("to_n_done", n_done, 0);
    check_val("to_busy_after", extra_busy, 0);
    pll_locked = 1'b1;
    repeat (3) tick();

    // Reset during the first C0 write.
    cfg_n = 18'h00101; cfg_m = 18'h01616; cfg_c0 = 18'h20303; cfg_c1 = 18'h00404;
    cfg_req = 1'b1;
    cyc = 0;
    while (cyc < 50 && !(mgmt_write && mgmt_address == 6'h05)) begin
      tick();
      cyc++;
      cfg_req = 1'b0;
    end
    check_val("rstmid_reached_c0", {mgmt_write, mgmt_address}, {1'b1, 6'h05});
    mgmt_reset_n = 1'b0;
    tick();
    check_val("rstmid_write", mgmt_write, 0);
    check_val("rstmid_busy", busy, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (done || error) bad++;
      tick();
    end
    mgmt_reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (done || error || busy) bad++;
      tick();
    end
    check_val("rstmid_no_pulse", bad, 0);
    run_req(18'h00111, 18'h00222, 18'h00333, 18'h00444, 32'h8000_0000, 6'h3f, 0, 400);
    check_seq("after_rst", 18'h00111, 18'h00222, 18'h00333, 18'h00444, 32'h8000_0000);
    check_val("after_rst_done_cyc", done_cyc, NW + 2 + S);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_writer.md
Name: pll_reconfig_writer

Overview:
- Avalon-MM master that drives the management port of a reconfigurable fractional PLL, the writer side of the PLL reconfiguration interface.
- Accepts a new counter set (N, M, C0, C1, optional fractional K) from the system clock domain logic, writes the registers in a fixed order, and starts reconfiguration.
- Supervises the PLL `locked` output and reports done or error.
- Sits between the video/CPU clock-select logic and the PLL reconfig block in the sys layer.

Parameters:
- SETTLE_CYC, 64: cycles to wait after the START write before sampling `locked`.
- LOCK_TIMEOUT, 1048576: maximum cycles to wait for `locked` high after settle.
- TO_W, 21: timeout counter width; must satisfy 2^TO_W > LOCK_TIMEOUT.

Ports:
- mgmt_clk, in, 1: single clock; PLL management clock.
- mgmt_reset_n, in, 1: synchronous reset, active low.
- cfg_req, in, 1: one-cycle request strobe; sampled only in IDLE.
- cfg_n, in, 18: N counter word. [7:0] low, [15:8] high, [16] bypass, [17] odd.
- cfg_m, in, 18: M counter word, same format.
- cfg_c0, in, 18: C0 counter word, same format.
- cfg_c1, in, 18: C1 counter word, same format.
- cfg_k, in, 32: fractional K value.
- busy, out, 1: high from accepted request until done/error.
- done, out, 1: one-cycle pulse on successful relock.
- error, out, 1: one-cycle pulse on lock timeout.
- mgmt_address, out, 6: register address.
- mgmt_write, out, 1: write strobe.
- mgmt_writedata, out, 32: write data.
- mgmt_waitrequest, in, 1: slave stall.
- pll_locked, in, 1: PLL lock, asynchronous to mgmt_clk.

Behaviour:
- Reset: all outputs low; mgmt_address=0, mgmt_writedata=0; FSM in IDLE; cfg latches cleared; timeout counter 0.
- pll_locked passes through a 2-flop synchronizer before use. This adds 2 cycles of latency.
- IDLE:
  - On cfg_req=1: latch all cfg_* inputs, assert busy next cycle, go to WR.
  - cfg_req in any other state is ignored.
- WR: issues the following sequence, one Avalon write per step:
  - addr 0x00, data 0 (waitrequest mode)
  - addr 0x03, data {14'b0, n}
  - addr 0x04, data {14'b0, m}
  - addr 0x07, data k (only with feature)
  - addr 0x05, data {9'b0, 5'd0, c0}
  - addr 0x05, data {9'b0, 5'd1, c1}
  - addr 0x02, data 1 (start)
- Write handshake:
  - mgmt_write, address and data are asserted together and held stable while mgmt_waitrequest=1.
  - The write completes on the first cycle with mgmt_write=1 and mgmt_waitrequest=0.
  - The next write may begin the following cycle, giving back-to-back throughput of 1 write/cycle with no waitrequest.
  - mgmt_write is never asserted outside WR.
- SETTLE: entered after the START write completes.
  - Count SETTLE_CYC cycles, then go to LOCKWAIT.
  - Timeout counter cleared on entry.
- LOCKWAIT:
  - Synced locked=1 → DONE.
  - Counter reaching LOCK_TIMEOUT-1 without lock → ERR.
  - Lock and timeout in the same cycle: lock wins → DONE.
- DONE / ERR:
  - Pulse done or error for exactly 1 cycle.
  - busy deasserts in that same cycle.
  - Return to IDLE.
  - A cfg_req arriving in the DONE/ERR cycle is ignored.
- Latched cfg values are unaffected by input changes while busy.
- Reset mid-operation: immediate return to IDLE on the next edge; mgmt_write drops; no done or error pulse.
- Total minimum latency, zero-wait slave, locked already high after settle: 1 (accept) + 6 writes + SETTLE_CYC + 1 (lock check) + 2 (synchronizer, already satisfied) → done at cycle 8+SETTLE_CYC after cfg_req.

Optional Feature:
- PLLCFG_FRAC_EN defined:
  - The K write (addr 0x07, data cfg_k) is inserted between M and C0, making 7 writes.
  - cfg_k is latched.
- Not defined:
  - K write omitted; cfg_k is ignored and unlatched.
  - The port remains present for interface stability.

Test Plan:
- Reset, no request → all outputs 0, busy=0 for 100 cycles, mgmt_write never asserted.
- cfg_req with n=0x00101, m=0x01616, c0=0x20303, c1=0x00404, waitrequest=0, locked=1:
  - Address/data sequence is 0x00/0, 0x03/0x00101, 0x04/0x01616, 0x05/0x20303, 0x05/0x00404|1<<18, 0x02/1.
  - done pulses once at cycle 8+SETTLE_CYC.
- Waitrequest held high 5 cycles on the M write → address, data and write stable all 5 cycles; sequence continues unchanged; total latency +5.
- locked forced low for the whole request with LOCK_TIMEOUT=200 → error pulses exactly once, 200 cycles after settle; done never asserts; busy falls.
- mgmt_reset_n low during the C0 write:
  - mgmt_write=0 next cycle, busy=0, no done/error.
  - A new request afterwards completes normally.
- PLLCFG_FRAC_EN defined, cfg_k=0x80000000 → 0x07/0x80000000 appears between the 0x04 and 0x05 writes; done latency becomes 9+SETTLE_CYC.
